// File: rtl/relu_quant_map_writer.sv
// relu_quant_map_writer
// Takes per-core convolution accumulators, applies ReLU, a rounding right
// shift and 16-bit saturation, and writes one row-major feature map per core
// into the average-pool input BRAMs at addresses 0..map_size^2-1. A one-cycle
// done pulse tells the controller the map is complete.
module relu_quant_map_writer #(
    parameter int COMPUTING_CORES             = 4,
    parameter int ACC_DATAWIDTH               = 32,
    parameter int number_datawidth            = 16,
    parameter int input_map_address_datawidth = 13,
    parameter int FRAC_SHIFT                  = 8,
    parameter int SIZE_DATAWIDTH              = 7
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   start,
    input  logic [SIZE_DATAWIDTH-1:0]                              map_size,
    input  logic                                                   in_valid,
    output logic                                                   in_ready,
    input  logic [COMPUTING_CORES*ACC_DATAWIDTH-1:0]               in_data,
    output logic [COMPUTING_CORES-1:0]                             wr_ena,
    output logic [COMPUTING_CORES*input_map_address_datawidth-1:0] BRAM_Wr_Address,
    output logic [COMPUTING_CORES*number_datawidth-1:0]            BRAM_Wr_Data,
    output logic                                                   busy,
    output logic                                                   done
);

    localparam int ACC_W  = ACC_DATAWIDTH;
    localparam int NUM_W  = number_datawidth;
    localparam int ADDR_W = input_map_address_datawidth;
    // Count and total must hold map_size^2, so they are twice the size width.
    localparam int CNT_W  = 2 * SIZE_DATAWIDTH;

    // Half an LSB of the quantised result, added before truncation for round-half-up.
    localparam logic [ACC_W:0] ROUND_BIAS = (ACC_W+1)'(1) << (FRAC_SHIFT - 1);
    // Largest positive value of a signed NUM_W-bit word.
    localparam logic [ACC_W:0] SAT_MAX    = ((ACC_W+1)'(1) << (NUM_W - 1)) - (ACC_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   total;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   size_sq;
    logic               accept;

    // ReLU, rounding shift and saturation of one lane. The extra top bit of
    // the intermediate keeps the rounding add from wrapping on large inputs.
    function automatic logic [NUM_W-1:0] quantise(input logic [ACC_W-1:0] x);
        logic [ACC_W:0] sum;
        logic [ACC_W:0] r;
        sum = {1'b0, x} + ROUND_BIAS;
        r   = sum >> FRAC_SHIFT;
        if (x[ACC_W-1])
            quantise = '0;
        else if (r > SAT_MAX)
            quantise = SAT_MAX[NUM_W-1:0];
        else
            quantise = r[NUM_W-1:0];
    endfunction

    assign size_sq  = CNT_W'(map_size) * CNT_W'(map_size);
    assign in_ready = (state == S_RUN);
    assign accept   = in_valid && in_ready;

    // Map sequencing plus the registered write port: every accepted beat
    // becomes one write on all lanes in the following cycle, at the
    // pre-increment count. Address and data hold between writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            total           <= '0;
            count           <= '0;
            wr_ena          <= '0;
            BRAM_Wr_Address <= '0;
            BRAM_Wr_Data    <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            wr_ena <= '0;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        total <= size_sq;
                        count <= '0;
                        if (map_size == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        wr_ena <= '1;
                        for (int i = 0; i < COMPUTING_CORES; i++) begin
                            BRAM_Wr_Address[ADDR_W*i +: ADDR_W] <= ADDR_W'(count);
                            BRAM_Wr_Data[NUM_W*i +: NUM_W]      <= quantise(in_data[ACC_W*i +: ACC_W]);
                        end
                        count <= count + CNT_W'(1);
                        if (count == total - CNT_W'(1))
                            state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_relu_quant_map_writer.sv
// tb_relu_quant_map_writer
// Drives directed and randomized maps into relu_quant_map_writer and compares
// every cycle against a behavioural model built from the map-writing rules.
module tb_relu_quant_map_writer;

    localparam int CORES = 4;
    localparam int ACC   = 32;
    localparam int NUM   = 16;
    localparam int AW    = 13;
    localparam int FRAC  = 8;
    localparam int SW    = 7;
    localparam longint HALF = longint'(1) << (FRAC - 1);
    localparam longint ONE  = longint'(1) << FRAC;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FLUSH = 2;
    localparam int M_DONE  = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic [SW-1:0]          map_size;
    logic                   in_valid;
    logic                   in_ready;
    logic [CORES*ACC-1:0]   in_data;
    logic [CORES-1:0]       wr_ena;
    logic [CORES*AW-1:0]    BRAM_Wr_Address;
    logic [CORES*NUM-1:0]   BRAM_Wr_Data;
    logic                   busy;
    logic                   done;

    relu_quant_map_writer dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .map_size        (map_size),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .wr_ena          (wr_ena),
        .BRAM_Wr_Address (BRAM_Wr_Address),
        .BRAM_Wr_Data    (BRAM_Wr_Data),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    // Model state
    int               m_phase = M_IDLE;
    int               m_total = 0;
    int               m_next  = 0;
    int               m_doneCnt = 0;
    logic             m_wr = 1'b0;
    logic [AW-1:0]    m_addr = '0;
    logic [CORES*NUM-1:0] m_data = '0;
    logic             m_busy = 1'b0;
    logic             m_done = 1'b0;
    logic             armed = 1'b0;

    // Monitor counters
    int               cyc = 0;
    int               monWrites = 0;
    int               monDones = 0;
    int               lastWrCyc = 0;
    int               doneCyc = 0;
    logic [AW-1:0]    capAddr [16];
    logic [CORES*NUM-1:0] capData [16];

    logic [ACC-1:0]   tbl [4][CORES];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp)
            nPass++;
        else
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic reportTimeout(input string name);
        nChecks++;
        $display("[TB] FAIL %s timeout waiting for done", name);
    endtask

    // Reference quantiser in plain integer arithmetic
    function automatic logic [NUM-1:0] qref(input logic [ACC-1:0] x);
        longint v;
        longint r;
        v = longint'(signed'(x));
        if (v < 0)
            return '0;
        r = (v + HALF) / ONE;
        if (r > 32767)
            r = 32767;
        return NUM'(r);
    endfunction

    function automatic logic [ACC-1:0] randAcc();
        int sel;
        sel = $urandom_range(0, 4);
        case (sel)
            0: return ACC'($urandom);
            1: return ACC'($urandom_range(0, 32'h00FF_FFFF));
            2: return ~ACC'($urandom_range(0, 65535));
            3: return ACC'($urandom_range(0, 4095)) * 256 + ACC'(127 + $urandom_range(0, 1));
            default: return 32'h7F00_0000 + ACC'($urandom_range(0, 32'h00FF_FFFF));
        endcase
    endfunction

    // Behavioural model: a map is total=size^2 beats; each accepted beat is
    // written next cycle at its beat index; done follows the last write.
    always @(posedge clk) begin
        if (reset) begin
            armed   = 1'b1;
            m_phase = M_IDLE;
            m_wr    = 1'b0;
            m_addr  = '0;
            m_data  = '0;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_next  = 0;
        end else begin
            m_wr   = 1'b0;
            m_done = 1'b0;
            if (m_phase == M_IDLE) begin
                if (start) begin
                    m_total = int'(map_size) * int'(map_size);
                    m_next  = 0;
                    if (m_total == 0) begin
                        m_phase = M_DONE;
                        m_done  = 1'b1;
                        m_doneCnt++;
                    end else begin
                        m_phase = M_RUN;
                        m_busy  = 1'b1;
                    end
                end
            end else if (m_phase == M_RUN) begin
                if (in_valid) begin
                    m_wr   = 1'b1;
                    m_addr = AW'(m_next);
                    for (int i = 0; i < CORES; i++)
                        m_data[NUM*i +: NUM] = qref(in_data[ACC*i +: ACC]);
                    m_next++;
                    if (m_next == m_total)
                        m_phase = M_FLUSH;
                end
            end else if (m_phase == M_FLUSH) begin
                m_phase = M_DONE;
                m_done  = 1'b1;
                m_busy  = 1'b0;
                m_doneCnt++;
            end else begin
                m_phase = M_IDLE;
            end
        end
    end

    // Compare DUT against model on every falling edge, and log writes/dones
    always @(negedge clk) begin
        cyc++;
        if (armed) begin
            checkOutput("wr_ena",   64'(wr_ena),          m_wr ? 64'hF : 64'h0);
            checkOutput("address",  64'(BRAM_Wr_Address), 64'({CORES{m_addr}}));
            checkOutput("data",     64'(BRAM_Wr_Data),    64'(m_data));
            checkOutput("busy",     64'(busy),            64'(m_busy));
            checkOutput("done",     64'(done),            64'(m_done));
            checkOutput("in_ready", 64'(in_ready),        64'(m_phase == M_RUN));
        end
        if (wr_ena != '0) begin
            if (monWrites < 16) begin
                capAddr[monWrites] = BRAM_Wr_Address[AW-1:0];
                capData[monWrites] = BRAM_Wr_Data;
            end
            monWrites++;
            lastWrCyc = cyc;
        end
        if (done) begin
            monDones++;
            doneCyc = cyc;
        end
    end

    task automatic clearMonitor();
        @(negedge clk);
        #1;
        monWrites = 0;
        monDones  = 0;
    endtask

    task automatic driveRandomLanes();
        for (int i = 0; i < CORES; i++)
            in_data[ACC*i +: ACC] = randAcc();
    endtask

    // Start a map and feed randomized beats until the model reports done
    task automatic applyStimulus(input int ms, input int pct, input bit glitch);
        int base;
        int n;
        base = m_doneCnt;
        n = 0;
        @(negedge clk);
        start = 1'b1;
        map_size = SW'(ms);
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (m_doneCnt == base && n < 30000) begin
            in_valid = ($urandom_range(0, 99) < pct);
            driveRandomLanes();
            if (glitch && (n == 4 || n == 7)) begin
                start = 1'b1;
                map_size = SW'(5);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (m_doneCnt == base)
            reportTimeout("random_map");
        repeat (2) @(negedge clk);
        #1;
    endtask

    // Start a 2x2 map and feed the four beats of tbl back to back
    task automatic runDirected();
        @(negedge clk);
        start = 1'b1;
        map_size = SW'(2);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            for (int i = 0; i < CORES; i++)
                in_data[ACC*i +: ACC] = tbl[k][i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
    endtask

    logic [ACC-1:0] edgeVals [4];
    logic [NUM-1:0] edgeExp  [4];

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        map_size = '0;
        in_valid = 1'b0;
        in_data = '0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_wr_ena", 64'(wr_ena), 64'h0);
        checkOutput("reset_addr",   64'(BRAM_Wr_Address), 64'h0);
        checkOutput("reset_data",   64'(BRAM_Wr_Data), 64'h0);
        checkOutput("reset_busy",   64'(busy), 64'h0);
        checkOutput("reset_done",   64'(done), 64'h0);
        checkOutput("reset_ready",  64'(in_ready), 64'h0);
        reset = 1'b0;

        // Pin the reference quantiser itself
        checkOutput("qref_17F",  64'(qref(32'h0000_017F)), 64'h1);
        checkOutput("qref_180",  64'(qref(32'h0000_0180)), 64'h2);
        checkOutput("qref_neg",  64'(qref(32'hFFFF_FF00)), 64'h0);
        checkOutput("qref_sat",  64'(qref(32'h7FFF_FFFF)), 64'h7FFF);

        // 2x2 map, lane i beat k = (4i+k+1)<<8 -> data 4i+k+1 at address k
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < CORES; i++)
                tbl[k][i] = ACC'((4 * i + k + 1) * 256);
        clearMonitor();
        runDirected();
        checkOutput("small_writes", 64'(monWrites), 64'd4);
        checkOutput("small_dones",  64'(monDones), 64'd1);
        checkOutput("small_done_lat", 64'(doneCyc - lastWrCyc), 64'd1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("small_addr", 64'(capAddr[k]), 64'(k));
            for (int i = 0; i < CORES; i++)
                checkOutput("small_lane", 64'(capData[k][NUM*i +: NUM]), 64'(4 * i + k + 1));
        end

        // Rounding / ReLU / saturation edge values, rotated across lanes
        edgeVals[0] = 32'h0000_017F; edgeExp[0] = 16'h0001;
        edgeVals[1] = 32'h0000_0180; edgeExp[1] = 16'h0002;
        edgeVals[2] = 32'hFFFF_FF00; edgeExp[2] = 16'h0000;
        edgeVals[3] = 32'h7FFF_FFFF; edgeExp[3] = 16'h7FFF;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < CORES; i++)
                tbl[k][i] = edgeVals[(k + i) % 4];
        clearMonitor();
        runDirected();
        checkOutput("edge_writes", 64'(monWrites), 64'd4);
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < CORES; i++)
                checkOutput("edge_lane", 64'(capData[k][NUM*i +: NUM]), 64'(edgeExp[(k + i) % 4]));

        // Full 80x80 map with ~50% valid
        clearMonitor();
        applyStimulus(80, 50, 1'b0);
        checkOutput("big_writes", 64'(monWrites), 64'd6400);
        checkOutput("big_dones",  64'(monDones), 64'd1);
        checkOutput("big_first_addr", 64'(capAddr[0]), 64'd0);

        // map_size 0: done right after start is sampled, no writes
        clearMonitor();
        start = 1'b1;
        map_size = '0;
        @(negedge clk);
        start = 1'b0;
        #1;
        checkOutput("zero_done", 64'(done), 64'h1);
        checkOutput("zero_busy", 64'(busy), 64'h0);
        @(negedge clk);
        #1;
        checkOutput("zero_done_clear", 64'(done), 64'h0);
        checkOutput("zero_writes", 64'(monWrites), 64'd0);

        // Start pulses while busy are ignored
        clearMonitor();
        applyStimulus(3, 70, 1'b1);
        checkOutput("glitch_writes", 64'(monWrites), 64'd9);
        checkOutput("glitch_dones",  64'(monDones), 64'd1);

        // Reset after 10 writes of a 14x14 map, then full restart
        clearMonitor();
        start = 1'b1;
        map_size = SW'(14);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (monWrites < 10 && n < 100) begin
            in_valid = 1'b1;
            driveRandomLanes();
            @(negedge clk);
            #1;
            n++;
        end
        if (monWrites < 10)
            reportTimeout("abort_fill");
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("abort_wr_ena", 64'(wr_ena), 64'h0);
        checkOutput("abort_addr",   64'(BRAM_Wr_Address), 64'h0);
        checkOutput("abort_data",   64'(BRAM_Wr_Data), 64'h0);
        checkOutput("abort_busy",   64'(busy), 64'h0);
        checkOutput("abort_ready",  64'(in_ready), 64'h0);
        checkOutput("abort_writes", 64'(monWrites), 64'd10);
        checkOutput("abort_dones",  64'(monDones), 64'd0);
        reset = 1'b0;
        clearMonitor();
        applyStimulus(14, 80, 1'b0);
        checkOutput("restart_writes", 64'(monWrites), 64'd196);
        checkOutput("restart_addr0",  64'(capAddr[0]), 64'd0);
        checkOutput("restart_dones",  64'(monDones), 64'd1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
